// File: rtl/ddr_line_pkg.sv
// Shared definitions for the cache-line DDR initiator.
//   line_state_e   : master FSM states
//   AXI_BURST_INCR : incrementing burst encoding on arw_burst
//   AXI_SIZE_4B    : beat size code driven on arw_size
//   AXI_RESP_OKAY  : good completion code on bresp/rresp
package ddr_line_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ADDR,
    ST_WDATA,
    ST_WRESP,
    ST_RDATA,
    ST_DONE
  } line_state_e;

  localparam logic [1:0] AXI_BURST_INCR = 2'b01;
  localparam logic [2:0] AXI_SIZE_4B    = 3'b010;
  localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;

endpackage

// File: rtl/ddr_line_master.sv
// ddr_line_master: accepts one whole cache line (write) or a line request
// (read) from a client, issues a single INCR burst of LINE_BEATS 64-bit beats
// on the controller's combined address channel, and returns a completion or
// the filled line on a valid/ready response port. One request in flight.
//
// Ports
//   clk, reset_n                 : clock, asynchronous active-low reset
//   req_*                        : client request (valid/ready, write flag,
//                                  byte address, line data and strobes)
//   resp_*                       : client response (valid/ready, write echo,
//                                  read line, error flag)
//   arw_*                        : combined read/write address channel
//   wvalid..wstrb                : write data channel
//   bvalid..bid                  : write response channel
//   rvalid..rid                  : read data channel
module ddr_line_master
  import ddr_line_pkg::*;
#(
  parameter int          ADDR_BITS  = 27,
  parameter int          LINE_BEATS = 4,
  parameter int          ID_WIDTH   = 1,
  parameter int unsigned MASTER_ID  = 0
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic                    req_write,
  input  logic [ADDR_BITS-1:0]    req_addr,
  input  logic [64*LINE_BEATS-1:0] req_wdata,
  input  logic [8*LINE_BEATS-1:0] req_wstrb,
  output logic                    resp_valid,
  input  logic                    resp_ready,
  output logic                    resp_write,
  output logic [64*LINE_BEATS-1:0] resp_rdata,
  output logic                    resp_err,
  output logic                    arw_valid,
  input  logic                    arw_ready,
  output logic [ADDR_BITS-1:0]    arw_addr,
  output logic [7:0]              arw_len,
  output logic                    arw_write,
  output logic [ID_WIDTH-1:0]     arw_id,
  output logic [2:0]              arw_size,
  output logic [1:0]              arw_burst,
  output logic                    arw_allStrb,
  output logic                    wvalid,
  input  logic                    wready,
  output logic                    wlast,
  output logic [63:0]             wdata,
  output logic [7:0]              wstrb,
  input  logic                    bvalid,
  output logic                    bready,
  input  logic [1:0]              bresp,
  input  logic [ID_WIDTH-1:0]     bid,
  input  logic                    rvalid,
  output logic                    rready,
  input  logic                    rlast,
  input  logic [1:0]              rresp,
  input  logic [63:0]             rdata,
  input  logic [ID_WIDTH-1:0]     rid
);

  localparam int IDX_W = $clog2(LINE_BEATS);
  localparam int CNT_W = IDX_W + 1;
  localparam int OFF_W = $clog2(LINE_BEATS * 8);
  localparam logic [CNT_W-1:0]    LAST_BEAT = CNT_W'(LINE_BEATS - 1);
  localparam logic [ID_WIDTH-1:0] MID       = ID_WIDTH'(MASTER_ID);

  line_state_e            state_q;
  logic [CNT_W-1:0]       beat_cnt_q;
  logic                   err_q;
  logic                   write_q;
  // Line buffer: {strobes, data} per beat, shared by write issue and read fill.
  logic [71:0]            line_q [LINE_BEATS];

  logic                   arw_valid_q;
  logic [ADDR_BITS-1:0]   arw_addr_q;
  logic [7:0]             arw_len_q;
  logic                   arw_all_strb_q;
  logic                   wvalid_q;
  logic                   wlast_q;
  logic [63:0]            wdata_q;
  logic [7:0]             wstrb_q;
  logic                   bready_q;
  logic                   rready_q;
  logic                   resp_valid_q;

  logic [71:0]            req_beat [LINE_BEATS];
  logic [ADDR_BITS-1:0]   aligned_addr;
  logic [IDX_W-1:0]       beat_idx;
  logic [IDX_W-1:0]       next_idx;
  logic                   at_last;
  logic                   b_bad;
  logic                   r_bad;

  for (genvar gi = 0; gi < LINE_BEATS; gi++) begin : g_beat
    assign req_beat[gi] = {req_wstrb[gi*8 +: 8], req_wdata[gi*64 +: 64]};
    assign resp_rdata[gi*64 +: 64] = line_q[gi][63:0];
  end

  assign aligned_addr = {req_addr[ADDR_BITS-1:OFF_W], {OFF_W{1'b0}}};
  assign beat_idx     = beat_cnt_q[IDX_W-1:0];
  assign next_idx     = beat_idx + 1'b1;
  assign at_last      = (beat_cnt_q == LAST_BEAT);
  assign b_bad        = (bresp != AXI_RESP_OKAY) || (bid != MID);
  // rlast must coincide exactly with the final beat; either side of it is an error.
  assign r_bad        = (rresp != AXI_RESP_OKAY) || (rid != MID) || (rlast != at_last);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q        <= ST_IDLE;
      beat_cnt_q     <= '0;
      err_q          <= 1'b0;
      write_q        <= 1'b0;
      arw_valid_q    <= 1'b0;
      arw_addr_q     <= '0;
      arw_len_q      <= '0;
      arw_all_strb_q <= 1'b0;
      wvalid_q       <= 1'b0;
      wlast_q        <= 1'b0;
      wdata_q        <= '0;
      wstrb_q        <= '0;
      bready_q       <= 1'b0;
      rready_q       <= 1'b0;
      resp_valid_q   <= 1'b0;
      for (int i = 0; i < LINE_BEATS; i++) line_q[i] <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (req_valid) begin
            for (int i = 0; i < LINE_BEATS; i++) line_q[i] <= req_beat[i];
            write_q        <= req_write;
            arw_addr_q     <= aligned_addr;
            arw_len_q      <= 8'(LINE_BEATS - 1);
            arw_all_strb_q <= req_write ? &req_wstrb : 1'b1;
            beat_cnt_q     <= '0;
            err_q          <= 1'b0;
            arw_valid_q    <= 1'b1;
            state_q        <= ST_ADDR;
          end
        end
        ST_ADDR: begin
          if (arw_ready) begin
            arw_valid_q <= 1'b0;
            if (write_q) begin
              wvalid_q <= 1'b1;
              wdata_q  <= line_q[0][63:0];
              wstrb_q  <= line_q[0][71:64];
              wlast_q  <= 1'b0;  // a line always has at least two beats
              state_q  <= ST_WDATA;
            end else begin
              rready_q <= 1'b1;
              state_q  <= ST_RDATA;
            end
          end
        end
        ST_WDATA: begin
          if (wready) begin
            beat_cnt_q <= beat_cnt_q + 1'b1;
            if (at_last) begin
              wvalid_q <= 1'b0;
              wlast_q  <= 1'b0;
              bready_q <= 1'b1;
              state_q  <= ST_WRESP;
            end else begin
              wdata_q <= line_q[next_idx][63:0];
              wstrb_q <= line_q[next_idx][71:64];
              wlast_q <= (beat_cnt_q + 1'b1 == LAST_BEAT);
            end
          end
        end
        ST_WRESP: begin
          if (bvalid) begin
            err_q        <= err_q | b_bad;
            bready_q     <= 1'b0;
            resp_valid_q <= 1'b1;
            state_q      <= ST_DONE;
          end
        end
        ST_RDATA: begin
          if (rvalid) begin
            line_q[beat_idx][63:0] <= rdata;
            beat_cnt_q             <= beat_cnt_q + 1'b1;
            err_q                  <= err_q | r_bad;
            if (rlast || at_last) begin
              rready_q     <= 1'b0;
              resp_valid_q <= 1'b1;
              state_q      <= ST_DONE;
            end
          end
        end
        ST_DONE: begin
          if (resp_ready) begin
            resp_valid_q <= 1'b0;
            state_q      <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign req_ready   = (state_q == ST_IDLE);
  assign resp_valid  = resp_valid_q;
  assign resp_write  = write_q;
  assign resp_err    = err_q;
  assign arw_valid   = arw_valid_q;
  assign arw_addr    = arw_addr_q;
  assign arw_len     = arw_len_q;
  assign arw_write   = write_q;
  assign arw_id      = MID;
  assign arw_size    = AXI_SIZE_4B;
  assign arw_burst   = AXI_BURST_INCR;
  assign arw_allStrb = arw_all_strb_q;
  assign wvalid      = wvalid_q;
  assign wlast       = wlast_q;
  assign wdata       = wdata_q;
  assign wstrb       = wstrb_q;
  assign bready      = bready_q;
  assign rready      = rready_q;

endmodule

// File: tb/tb_ddr_line_master.sv
// Bench for ddr_line_master: a cycle-level controller/DDR responder with its
// own memory, plus a line-level reference memory that predicts every read
// line and error flag from the requests and the responder configuration.
`define CHK(t, o, e) check(t, 64'(o), 64'(e))

module tb_ddr_line_master;

  localparam int AB = 27;
  localparam int LB = 4;
  localparam int LW = 64 * LB;

  localparam int RS_IDLE = 0, RS_ADDR = 1, RS_ACK = 2, RS_W = 3, RS_WDONE = 4,
                 RS_B = 5, RS_BACK = 6, RS_R = 7, RS_RDONE = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            reset_n;
  logic            req_valid, req_ready, req_write;
  logic [AB-1:0]   req_addr;
  logic [LW-1:0]   req_wdata;
  logic [8*LB-1:0] req_wstrb;
  logic            resp_valid, resp_ready, resp_write, resp_err;
  logic [LW-1:0]   resp_rdata;
  logic            arw_valid, arw_ready, arw_write, arw_allStrb;
  logic [AB-1:0]   arw_addr;
  logic [7:0]      arw_len;
  logic [0:0]      arw_id;
  logic [2:0]      arw_size;
  logic [1:0]      arw_burst;
  logic            wvalid, wready, wlast;
  logic [63:0]     wdata;
  logic [7:0]      wstrb;
  logic            bvalid, bready;
  logic [1:0]      bresp;
  logic [0:0]      bid;
  logic            rvalid, rready, rlast;
  logic [1:0]      rresp;
  logic [63:0]     rdata;
  logic [0:0]      rid;

  ddr_line_master #(.ADDR_BITS(AB), .LINE_BEATS(LB), .ID_WIDTH(1), .MASTER_ID(0)) dut (
    .clk(clk), .reset_n(reset_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_wstrb(req_wstrb),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_write(resp_write),
    .resp_rdata(resp_rdata), .resp_err(resp_err),
    .arw_valid(arw_valid), .arw_ready(arw_ready), .arw_addr(arw_addr), .arw_len(arw_len),
    .arw_write(arw_write), .arw_id(arw_id), .arw_size(arw_size), .arw_burst(arw_burst),
    .arw_allStrb(arw_allStrb),
    .wvalid(wvalid), .wready(wready), .wlast(wlast), .wdata(wdata), .wstrb(wstrb),
    .bvalid(bvalid), .bready(bready), .bresp(bresp), .bid(bid),
    .rvalid(rvalid), .rready(rready), .rlast(rlast), .rresp(rresp), .rdata(rdata), .rid(rid)
  );

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_vec = 0;
  int n_err = 0;
  int txn_no = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s (txn %0d): observed %h expected %h", tag, txn_no, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (reset_n === 1'b1) begin
      n_vec++;
      if (arw_size !== 3'b010) begin
        n_err++;
        $error("FAIL monitor arw_size: observed %h expected 2", arw_size);
      end
      if (arw_burst !== 2'b01) begin
        n_err++;
        $error("FAIL monitor arw_burst: observed %h expected 1", arw_burst);
      end
      if (arw_id !== 1'b0) begin
        n_err++;
        $error("FAIL monitor arw_id: observed %h expected 0", arw_id);
      end
      if ((wvalid & rready) !== 1'b0) begin
        n_err++;
        $error("FAIL monitor wvalid/rready overlap");
      end
      if ((wvalid & bready) !== 1'b0) begin
        n_err++;
        $error("FAIL monitor wvalid/bready overlap");
      end
      if ((wvalid & ~arw_write) !== 1'b0) begin
        n_err++;
        $error("FAIL monitor wvalid during read");
      end
    end
  end

  // Memories: ddr_mem is what the responder stores from W beats; ref_mem is
  // the line-level prediction built only from client requests.
  logic [63:0] ddr_mem [int unsigned];
  logic [63:0] ref_mem [int unsigned];

  function automatic logic [63:0] init_word(input int unsigned wa);
    return {wa ^ 32'hA5A5_0000, ~wa};
  endfunction
  function automatic logic [63:0] ddr_rd(input int unsigned wa);
    return ddr_mem.exists(wa) ? ddr_mem[wa] : init_word(wa);
  endfunction
  function automatic logic [63:0] ref_rd(input int unsigned wa);
    return ref_mem.exists(wa) ? ref_mem[wa] : init_word(wa);
  endfunction

  // Responder configuration (written by the main sequence before a request).
  int         cfg_hold, cfg_rlast_at, cfg_err_beat, cfg_wpct, cfg_rpct;
  logic [1:0] cfg_bresp, cfg_rresp;
  logic       cfg_bid, cfg_rid;

  int          rs = RS_IDLE;
  int          hold_left, wbeat, rbeat, bdly;
  int unsigned final_cyc;
  int unsigned base_wa;
  logic [AB-1:0] cap_addr;
  logic [7:0]  cap_len;
  logic        cap_write;

  task automatic resp_clear();
    arw_ready = 0; wready = 0; bvalid = 0; bresp = 0; bid = 0;
    rvalid = 0; rlast = 0; rresp = 0; rdata = '0; rid = 0;
    rs = RS_IDLE;
  endtask

  task automatic resp_step();
    logic [63:0] w;
    if (rs == RS_IDLE && arw_valid) begin
      cap_addr = arw_addr; cap_len = arw_len; cap_write = arw_write;
      base_wa = 32'(cap_addr) >> 3;
      hold_left = cfg_hold;
      rs = RS_ADDR;
    end
    if (rs == RS_ADDR) begin
      `CHK("arw_valid held", arw_valid, 1'b1);
      `CHK("arw_addr stable", arw_addr, cap_addr);
      `CHK("arw_len stable", arw_len, cap_len);
      `CHK("arw_write stable", arw_write, cap_write);
      if (hold_left == 0) begin
        arw_ready = 1;
        rs = RS_ACK;
      end else hold_left--;
    end else if (rs == RS_ACK) begin
      arw_ready = 0; wbeat = 0; rbeat = 0;
      `CHK("arw_valid drop", arw_valid, 1'b0);
      rs = cap_write ? RS_W : RS_R;
    end
    if (rs == RS_W) begin
      wready = ($urandom_range(99) < cfg_wpct);
      if (wready && wvalid) begin
        `CHK("wlast", wlast, wbeat == LB - 1);
        w = ddr_rd(base_wa + wbeat);
        for (int k = 0; k < 8; k++) if (wstrb[k]) w[k*8 +: 8] = wdata[k*8 +: 8];
        ddr_mem[base_wa + wbeat] = w;
        wbeat++;
        if (wbeat == LB) rs = RS_WDONE;
      end
    end else if (rs == RS_WDONE) begin
      wready = 0;
      `CHK("wvalid drop", wvalid, 1'b0);
      bdly = $urandom_range(2);
      rs = RS_B;
    end
    if (rs == RS_B) begin
      if (bdly == 0) begin
        `CHK("bready", bready, 1'b1);
        bvalid = 1; bresp = cfg_bresp; bid = cfg_bid;
        final_cyc = cyc + 1;
        rs = RS_BACK;
      end else bdly--;
    end else if (rs == RS_BACK) begin
      bvalid = 0; bresp = 0; bid = 0;
      rs = RS_IDLE;
    end
    if (rs == RS_R) begin
      rvalid = 0; rlast = 0; rresp = 0;
      if ($urandom_range(99) < cfg_rpct) begin
        `CHK("rready", rready, 1'b1);
        rvalid = 1;
        rdata  = ddr_rd(base_wa + rbeat);
        rlast  = (rbeat == cfg_rlast_at);
        rresp  = (rbeat == cfg_err_beat) ? cfg_rresp : 2'b00;
        rid    = cfg_rid;
        if (rlast || rbeat == LB - 1) begin
          final_cyc = cyc + 1;
          rs = RS_RDONE;
        end
        rbeat++;
      end
    end else if (rs == RS_RDONE) begin
      rvalid = 0; rlast = 0; rresp = 0; rid = 0;
      `CHK("rready drop", rready, 1'b0);
      rs = RS_IDLE;
    end
  endtask

  initial begin
    resp_clear();
    forever begin
      @(negedge clk);
      if (!reset_n) resp_clear();
      else resp_step();
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, observed time %0t", $time);
    $fatal(1, "watchdog");
  end

  task automatic cfg_ok();
    cfg_hold = $urandom_range(3); cfg_bresp = 0; cfg_bid = 0;
    cfg_rlast_at = LB - 1; cfg_err_beat = -1; cfg_rresp = 0; cfg_rid = 0;
    cfg_wpct = 70; cfg_rpct = 75;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset_n = 0; req_valid = 0; resp_ready = 0;
    repeat (3) @(negedge clk);
    reset_n = 1;
  endtask

  logic [LW-1:0] last_rdata;

  task automatic do_txn(input bit wr, input logic [AB-1:0] addr,
                        input logic [LW-1:0] wd, input logic [8*LB-1:0] ws);
    logic [AB-1:0] al;
    int unsigned   bw;
    int            t, d, delivered;
    logic          exp_err;
    logic [63:0]   w;
    txn_no++;
    al = addr & ~AB'(32'h1F);
    bw = 32'(al) >> 3;
    @(negedge clk);
    `CHK("req_ready idle", req_ready, 1'b1);
    req_valid = 1; req_write = wr; req_addr = addr; req_wdata = wd; req_wstrb = ws;
    @(negedge clk);
    req_valid = 0;
    req_wdata = {8{$urandom()}};
    req_wstrb = $urandom();
    `CHK("arw_valid latency", arw_valid, 1'b1);
    `CHK("arw_addr", arw_addr, al);
    `CHK("arw_len", arw_len, 8'(LB - 1));
    `CHK("arw_write", arw_write, wr);
    `CHK("arw_allStrb", arw_allStrb, wr ? &ws : 1'b1);
    `CHK("req_ready busy", req_ready, 1'b0);
    t = 0;
    while (!resp_valid && t < 2000) begin
      @(negedge clk);
      t++;
    end
    if (!resp_valid) begin
      `CHK("resp timeout", resp_valid, 1'b1);
      do_reset();
    end else begin
      `CHK("resp latency", cyc, final_cyc);
      if (wr) begin
        exp_err = (cfg_bresp != 0) || (cfg_bid != 0);
        delivered = 0;
      end else begin
        delivered = ((cfg_rlast_at < LB - 1) ? cfg_rlast_at : LB - 1) + 1;
        exp_err = (cfg_rid != 0) || (cfg_rlast_at != LB - 1) ||
                  (cfg_err_beat >= 0 && cfg_err_beat < delivered && cfg_rresp != 0);
      end
      d = $urandom_range(3);
      repeat (d) begin
        `CHK("resp_valid held", resp_valid, 1'b1);
        @(negedge clk);
      end
      `CHK("resp_err", resp_err, exp_err);
      `CHK("resp_write", resp_write, wr);
      last_rdata = resp_rdata;
      for (int i = 0; i < delivered; i++)
        `CHK("resp_rdata beat", resp_rdata[i*64 +: 64], ref_rd(bw + i));
      if (wr) begin
        for (int b = 0; b < LB; b++) begin
          w = ref_rd(bw + b);
          for (int k = 0; k < 8; k++) if (ws[b*8 + k]) w[k*8 +: 8] = wd[b*64 + k*8 +: 8];
          ref_mem[bw + b] = w;
        end
      end
      resp_ready = 1;
      @(negedge clk);
      resp_ready = 0;
      `CHK("resp_valid drop", resp_valid, 1'b0);
      `CHK("req_ready after done", req_ready, 1'b1);
    end
    $display("txn %0d: %s addr=%h err=%0b", txn_no, wr ? "WR" : "RD", al, resp_err);
  endtask

  logic [LW-1:0]   wd;
  logic [8*LB-1:0] ws;
  logic [AB-1:0]   ad;
  int              t;

  initial begin
    reset_n = 1; req_valid = 0; req_write = 0; req_addr = '0;
    req_wdata = '0; req_wstrb = '0; resp_ready = 0;
    cfg_ok();
    #1 reset_n = 0;
    #2;
    `CHK("rst req_ready", req_ready, 1'b1);
    `CHK("rst arw_valid", arw_valid, 1'b0);
    `CHK("rst wvalid", wvalid, 1'b0);
    `CHK("rst bready", bready, 1'b0);
    `CHK("rst rready", rready, 1'b0);
    `CHK("rst resp_valid", resp_valid, 1'b0);
    `CHK("rst resp_err", resp_err, 1'b0);
    `CHK("rst arw_len", arw_len, 8'h00);
    `CHK("rst arw_allStrb", arw_allStrb, 1'b0);
    `CHK("rst wlast", wlast, 1'b0);
    `CHK("rst arw_size", arw_size, 3'b010);
    `CHK("rst arw_burst", arw_burst, 2'b01);
    `CHK("rst arw_id", arw_id, 1'b0);
    `CHK("rst resp_rdata", resp_rdata[63:0], 64'h0);
    repeat (3) @(negedge clk);
    reset_n = 1;
    @(negedge clk);
    `CHK("req_ready after reset", req_ready, 1'b1);

    // Directed line write then readback.
    cfg_ok(); cfg_hold = 0;
    wd = {64'h4444_4444_4444_4444, 64'h3333_3333_3333_3333,
          64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111};
    do_txn(1'b1, 27'h001_2340, wd, '1);
    cfg_ok();
    do_txn(1'b0, 27'h001_2340, '0, '0);
    `CHK("readback beat0", last_rdata[63:0], 64'h1111_1111_1111_1111);

    // Partial strobe on beat 2 only.
    cfg_ok();
    wd = {8{$urandom()}};
    ws = 32'h000F_0000;
    do_txn(1'b1, 27'h001_2340, wd, ws);
    cfg_ok();
    do_txn(1'b0, 27'h001_2340, '0, '0);
    `CHK("partial beat2", last_rdata[191:128], {32'h3333_3333, wd[159:128]});
    `CHK("partial beat1", last_rdata[127:64], 64'h2222_2222_2222_2222);

    // Refresh pending: address held off 20 cycles.
    cfg_ok(); cfg_hold = 20;
    do_txn(1'b0, 27'h001_2355, '0, '0);
    cfg_ok(); cfg_hold = 20;
    do_txn(1'b1, 27'h001_2360, {8{$urandom()}}, '1);

    // Stub: rlast on beat 2 carrying SLVERR.
    cfg_ok(); cfg_rlast_at = 2; cfg_err_beat = 2; cfg_rresp = 2'b10;
    do_txn(1'b0, 27'h001_2340, '0, '0);

    // Randomized traffic over a few lines with occasional error responses.
    for (int n = 0; n < 24; n++) begin
      cfg_ok();
      ad = 27'h010_0000 + AB'($urandom_range(3) * 32) + AB'($urandom_range(31));
      wd = {8{$urandom()}};
      ws = ($urandom_range(1) == 1) ? '1 : 32'($urandom());
      case ($urandom_range(9))
        0: cfg_bresp = 2'($urandom_range(1, 3));
        1: cfg_bid = 1;
        2: cfg_rlast_at = $urandom_range(LB - 2);
        3: cfg_rlast_at = LB + 3;
        4: begin cfg_err_beat = $urandom_range(LB - 1); cfg_rresp = 2'($urandom_range(1, 3)); end
        5: cfg_rid = 1;
        default: ;
      endcase
      do_txn($urandom_range(1) == 1, ad, wd, ws);
    end

    // Reset in the middle of a write data phase.
    cfg_ok(); cfg_hold = 0; cfg_wpct = 40;
    txn_no++;
    @(negedge clk);
    req_valid = 1; req_write = 1; req_addr = 27'h300_0000;
    req_wdata = {8{$urandom()}}; req_wstrb = '1;
    @(negedge clk);
    req_valid = 0;
    t = 0;
    while (!(rs == RS_W && wbeat >= 1 && wvalid) && t < 200) begin
      @(negedge clk);
      t++;
    end
    `CHK("reach WDATA", (rs == RS_W && wvalid), 1'b1);
    #2 reset_n = 0;
    #1;
    `CHK("async rst wvalid", wvalid, 1'b0);
    `CHK("async rst wlast", wlast, 1'b0);
    `CHK("async rst bready", bready, 1'b0);
    `CHK("async rst rready", rready, 1'b0);
    `CHK("async rst resp_valid", resp_valid, 1'b0);
    repeat (2) @(negedge clk);
    reset_n = 1;
    @(negedge clk);
    `CHK("req_ready after mid reset", req_ready, 1'b1);
    $display("txn %0d: WR reset mid-burst", txn_no);

    // Recovery traffic.
    cfg_ok();
    wd = {8{$urandom()}};
    do_txn(1'b1, 27'h001_2380, wd, '1);
    cfg_ok();
    do_txn(1'b0, 27'h001_2380, '0, '0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/ddr_line_master.md
# ddr_line_master

Cache-line initiator that sits in front of `DDRSdramController` and drives its combined read/write address channel, W, B and R channels. A client hands it one whole line (address, data, byte strobes) or asks for one. The block issues a single INCR burst of `LINE_BEATS` 64-bit beats and returns the filled line or a write completion through a valid/ready response port. One request is in flight at a time.

## Interface
- `ADDR_BITS`, 27: byte-address width; equals controller `ROW_BITS+COL_BITS+3`.
- `LINE_BEATS`, 4: 64-bit beats per line; power of two, 2..16.
- `ID_WIDTH`, 1: AXI ID width.
- `MASTER_ID`, 0: value driven on `arw_id`.
- `clk` in 1: single clock; everything is sampled on the rising edge.
- `reset_n` in 1: asynchronous, active-low reset.
- `req_valid` in 1: request present.
- `req_ready` out 1: block can accept a request.
- `req_write` in 1: 1 = line write, 0 = line read.
- `req_addr` in ADDR_BITS: byte address; low log2(LINE_BEATS*8) bits are ignored.
- `req_wdata` in 64*LINE_BEATS: write line; beat 0 occupies bits [63:0].
- `req_wstrb` in 8*LINE_BEATS: byte enables for the write line.
- `resp_valid` out 1: response held until accepted.
- `resp_ready` in 1: client accepts the response.
- `resp_write` out 1: echo of `req_write`.
- `resp_rdata` out 64*LINE_BEATS: read line; undefined for writes.
- `resp_err` out 1: any non-OKAY resp, ID mismatch, or early/missing `rlast`.
- `arw_valid`, `arw_ready`, `arw_addr[ADDR_BITS-1:0]`, `arw_len[7:0]`, `arw_write`, `arw_id`, `arw_size[2:0]`, `arw_burst[1:0]`, `arw_allStrb`: address channel (out, except `arw_ready`).
- `wvalid`, `wready`, `wlast`, `wdata[63:0]`, `wstrb[7:0]`: write data channel (out, except `wready`).
- `bvalid`, `bready`, `bresp[1:0]`, `bid`: write response channel (in, except `bready`).
- `rvalid`, `rready`, `rlast`, `rresp[1:0]`, `rdata[63:0]`, `rid`: read data channel (in, except `rready`).

## Operation
- FSM states: IDLE, ADDR, WDATA, WRESP, RDATA, DONE.
- IDLE:
  - `req_ready`=1.
  - On `req_valid`, latch the address (line-aligned), write flag, wdata and wstrb into the line buffer.
  - Clear `beat_cnt` and the error flag.
  - Go to ADDR.
- ADDR:
  - Drive `arw_valid`=1, `arw_addr`=aligned address, `arw_len`=LINE_BEATS-1, `arw_size`=3'b010, `arw_burst`=2'b01 (INCR).
  - Drive `arw_allStrb` = AND of the latched wstrb (writes) or 1 (reads), and `arw_id`=MASTER_ID.
  - When `arw_ready` is seen, go to WDATA (write) or RDATA (read).
- WDATA:
  - Drive `wvalid`=1, `wdata`/`wstrb` = buffer beat `beat_cnt`, and `wlast` = (`beat_cnt`==LINE_BEATS-1).
  - On `wvalid&wready`, increment `beat_cnt`; after the last beat, go to WRESP.
- WRESP:
  - `bready`=1.
  - On `bvalid`, set the error flag if `bresp`!=0 or `bid`!=MASTER_ID, then go to DONE.
- RDATA:
  - `rready`=1 unconditionally, because the controller ignores backpressure.
  - On each `rvalid`, store `rdata` into slot `beat_cnt` and increment `beat_cnt`.
  - Set the error flag on `rresp`!=0, `rid` mismatch, `rlast` before the final beat, or no `rlast` on the final beat.
  - Exit to DONE on `rlast` or on the final beat, whichever comes first.
- DONE:
  - `resp_valid`=1 with `resp_rdata`, `resp_write` and `resp_err` stable.
  - On `resp_ready`, go to IDLE.
- `beat_cnt` is log2(LINE_BEATS)+1 bits wide and never wraps; slot indexing uses only the low bits.
- All other states drive `arw_valid`/`wvalid`/`bready`/`rready` to 0.

## Timing
- Reset values:
  - All outputs are 0, except `arw_size`=3'b010, `arw_burst`=2'b01 and `arw_id`=MASTER_ID, which are constant.
  - The FSM is in IDLE, so `req_ready`=1 in the first cycle after reset deasserts.
- Request-to-`arw_valid` is 1 cycle. `arw_valid` stays high, with fields stable, until `arw_ready`.
- Write data: `wvalid` is asserted the cycle after the address handshake. Beats advance only on cycles where `wready`=1, including odd-cycle `wready` gaps.
- Read: data is captured in the same cycle as `rvalid`.
- `resp_valid` is asserted the cycle after the final B or R beat. A same-cycle `resp_ready` then returns to IDLE, so the next request is accepted 1 cycle later.
- Asynchronous reset mid-burst:
  - All valids/readys drop immediately.
  - The controller must be reset in the same event. Resetting the master alone leaves the controller mid-burst and is a system error.

## Structure
- `ddr_line_pkg` holds the FSM state enum plus the constants `AXI_BURST_INCR`, `AXI_SIZE_4B` and `AXI_RESP_OKAY`.
- Single module with no sub-module. The line buffer is a LINE_BEATS×(64+8) register array shared between write data and read capture.

## Test plan
- Write line at 0x0001_2340 (aligned to 0x0001_2340) with data 0x1111…/0x2222…/0x3333…/0x4444… and all strobes, into the controller plus DDR model.
  - Required: `arw_len`=3, `arw_allStrb`=1, 4 W beats with `wlast` on the 4th, and `resp_valid` with `resp_err`=0.
- Read back the same line.
  - Required: `resp_rdata` equals the written line and `resp_err`=0.
- Write with wstrb 0x0F on beat 2 only.
  - Required: `arw_allStrb`=0, and readback shows only bytes [3:0] of beat 2 changed.
- Request while a refresh is pending (`arw_ready` held 0 for 20 cycles).
  - Required: `arw_valid` is held and the fields are stable throughout; the burst then completes.
- Stub responder returns `rlast` on beat 2 with `rresp`=2'b10.
  - Required: DONE after beat 2 with `resp_err`=1.
- Assert `reset_n`=0 mid-WDATA.
  - Required: `wvalid`=0 with no clock edge needed, and `req_ready`=1 after release.
